// File: rtl/cube_pkg.sv
// Shared cube move definitions: face codes, legal turn range, move payload,
// scheduler FSM states and the move legality check.
package cube_pkg;

    localparam int unsigned FACE_W = 6;
    localparam int unsigned ROT_W  = 3;
    localparam int unsigned MOVE_W = FACE_W + ROT_W;

    localparam logic [FACE_W-1:0] FACE_U = 6'd0;
    localparam logic [FACE_W-1:0] FACE_L = 6'd1;
    localparam logic [FACE_W-1:0] FACE_F = 6'd2;
    localparam logic [FACE_W-1:0] FACE_R = 6'd3;
    localparam logic [FACE_W-1:0] FACE_B = 6'd4;
    localparam logic [FACE_W-1:0] FACE_D = 6'd5;

    localparam logic [ROT_W-1:0] ROT_MIN = 3'd1;
    localparam logic [ROT_W-1:0] ROT_MAX = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    typedef struct packed {
        logic [FACE_W-1:0] face;
        logic [ROT_W-1:0]  rot;
    } move_t;

    // A move is legal when it names a real face and turns it 1..3 quarters.
    function automatic logic move_legal(input move_t mv);
        return (mv.face <= FACE_D) && (mv.rot >= ROT_MIN) && (mv.rot <= ROT_MAX);
    endfunction

endpackage

// File: rtl/move_fifo.sv
// Move queue between the requester arbiter and the issue FSM.
// Ports: clk/rst (async, active-high), flush empties the queue,
// push/din write, pop/dout read the head (dout is the current head),
// full/empty status. Pointers carry one extra wrap bit for full/empty.
module move_fifo
    import cube_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = MOVE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign do_pop  = pop && !empty;
    // A push into a full queue is fine when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Pointer update; flush wins over any concurrent push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/move_scheduler.sv
// Cube move scheduler: arbitrates manual and auto move requests round-robin,
// queues legal moves, and issues one move per ISSUE cycle to the cube state
// block with a programmable idle gap between issues.
// Ports: clk, rst (async, active-high); m_*/a_* valid/face/rot/ready request
// handshakes; gap, pause, flush controls; nextFaceMove/nextRotation issued
// move (0/0 when no move); busy, sticky err, saturating move_cnt.
module move_scheduler
    import cube_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m_valid,
    input  logic [FACE_W-1:0] m_face,
    input  logic [ROT_W-1:0]  m_rot,
    output logic              m_ready,
    input  logic              a_valid,
    input  logic [FACE_W-1:0] a_face,
    input  logic [ROT_W-1:0]  a_rot,
    output logic              a_ready,
    input  logic [3:0]        gap,
    input  logic              pause,
    input  logic              flush,
    output logic [FACE_W-1:0] nextFaceMove,
    output logic [ROT_W-1:0]  nextRotation,
    output logic              busy,
    output logic              err,
    output logic [CNT_W-1:0]  move_cnt
);

    state_t            state;
    logic [3:0]        gap_cnt;
    logic              prio_m;
    logic [FACE_W-1:0] face_q;
    logic [ROT_W-1:0]  rot_q;

    logic  full;
    logic  empty;
    logic  can_acc;
    logic  both_valid;
    logic  accept;
    logic  push;
    logic  pop;
    move_t acc_mv;
    move_t head;

    // Arbitration: a lone requester always wins; on contention prio_m decides.
    assign both_valid = m_valid && a_valid;
    assign can_acc    = !rst && !flush && !full;
    assign m_ready    = can_acc && m_valid && (!a_valid || prio_m);
    assign a_ready    = can_acc && a_valid && (!m_valid || !prio_m);
    assign accept     = m_ready || a_ready;
    assign acc_mv     = m_ready ? move_t'{face: m_face, rot: m_rot}
                                : move_t'{face: a_face, rot: a_rot};
    assign push       = accept && move_legal(acc_mv);
    assign pop        = (state == ST_IDLE) && !empty && !pause && !flush;

    assign busy         = !empty || (state != ST_IDLE);
    assign nextFaceMove = face_q;
    assign nextRotation = rot_q;

    move_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (MOVE_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .din   (acc_mv),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // Issue FSM, arbiter priority, error flag and move counter.
    // The IDLE cycle before the next issue counts as one of the gap cycles,
    // so consecutive issues are spaced max(gap,1)+1 cycles apart.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            gap_cnt  <= '0;
            prio_m   <= 1'b1;
            err      <= 1'b0;
            move_cnt <= '0;
            face_q   <= '0;
            rot_q    <= '0;
        end else begin
            face_q <= '0;
            rot_q  <= '0;
            if (both_valid && can_acc) prio_m <= !prio_m;
            if (accept && !move_legal(acc_mv)) err <= 1'b1;
            if (flush) begin
                state   <= ST_IDLE;
                gap_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (pop) begin
                            state  <= ST_ISSUE;
                            face_q <= head.face;
                            rot_q  <= head.rot;
                            if (move_cnt != {CNT_W{1'b1}}) move_cnt <= move_cnt + CNT_W'(1);
                        end
                    end
                    ST_ISSUE: begin
                        if (gap > 4'd1) begin
                            state   <= ST_GAP;
                            gap_cnt <= gap - 4'd1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_GAP: begin
                        if (gap_cnt <= 4'd1) begin
                            state   <= ST_IDLE;
                            gap_cnt <= '0;
                        end else begin
                            gap_cnt <= gap_cnt - 4'd1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_move_scheduler.sv
// Directed self-checking bench for move_scheduler (DEPTH=8, CNT_W=16).
module tb_move_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_valid;
    logic [5:0]  m_face;
    logic [2:0]  m_rot;
    logic        m_ready;
    logic        a_valid;
    logic [5:0]  a_face;
    logic [2:0]  a_rot;
    logic        a_ready;
    logic [3:0]  gap;
    logic        pause;
    logic        flush;
    logic [5:0]  nextFaceMove;
    logic [2:0]  nextRotation;
    logic        busy;
    logic        err;
    logic [15:0] move_cnt;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    move_scheduler #(.DEPTH(8), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .m_valid      (m_valid),
        .m_face       (m_face),
        .m_rot        (m_rot),
        .m_ready      (m_ready),
        .a_valid      (a_valid),
        .a_face       (a_face),
        .a_rot        (a_rot),
        .a_ready      (a_ready),
        .gap          (gap),
        .pause        (pause),
        .flush        (flush),
        .nextFaceMove (nextFaceMove),
        .nextRotation (nextRotation),
        .busy         (busy),
        .err          (err),
        .move_cnt     (move_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Step to the next negedge; inputs change and outputs are sampled there.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Wait (bounded) for the next issued move and check its payload.
    task automatic wait_issue(input string tag, input logic [5:0] ef, input logic [2:0] er,
                              output int at);
        bit seen = 0;
        at = -1;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            if (nextRotation != 3'd0) begin
                seen = 1;
                at   = cycle;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $error("FAIL %s: observed=timeout expected=issue %0d/%0d", tag, ef, er);
        end else begin
            chk({tag, "_face"}, 32'(nextFaceMove), 32'(ef));
            chk({tag, "_rot"},  32'(nextRotation), 32'(er));
        end
    endtask

    task automatic push_m(input logic [5:0] f, input logic [2:0] r, input logic exp_rdy,
                          input string tag);
        m_valid = 1'b1; m_face = f; m_rot = r;
        #1 chk(tag, 32'(m_ready), 32'(exp_rdy));
        step(1);
    endtask

    initial begin
        int t_prev;
        int t_now;
        logic [5:0] f_exp [4];
        logic [2:0] r_exp [4];

        rst = 1'b1; m_valid = 1'b1; m_face = 6'd0; m_rot = 3'd1;
        a_valid = 1'b0; a_face = 6'd0; a_rot = 3'd0;
        gap = 4'd0; pause = 1'b0; flush = 1'b0;

        // Reset state
        step(2);
        chk("rst_m_ready", 32'(m_ready), 32'd0);
        chk("rst_rot", 32'(nextRotation), 32'd0);
        chk("rst_face", 32'(nextFaceMove), 32'd0);
        m_valid = 1'b0;
        rst = 1'b0;
        step(1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_cnt", 32'(move_cnt), 32'd0);

        // Single manual U/1, gap=0: visible after the second edge, one cycle
        push_m(6'd0, 3'd1, 1'b1, "t1_ready");
        m_valid = 1'b0;
        chk("t1_lat1_rot", 32'(nextRotation), 32'd0);
        step(1);
        chk("t1_face", 32'(nextFaceMove), 32'd0);
        chk("t1_rot", 32'(nextRotation), 32'd1);
        chk("t1_cnt", 32'(move_cnt), 32'd1);
        step(1);
        chk("t1_after_rot", 32'(nextRotation), 32'd0);
        chk("t1_busy", 32'(busy), 32'd0);

        // Contention: manual L/2 vs auto U/3 for four cycles, M,A,M,A
        pause = 1'b1;
        m_valid = 1'b1; m_face = 6'd1; m_rot = 3'd2;
        a_valid = 1'b1; a_face = 6'd0; a_rot = 3'd3;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("t2_m_ready%0d", i), 32'(m_ready), 32'((i % 2) == 0));
            chk($sformatf("t2_a_ready%0d", i), 32'(a_ready), 32'((i % 2) == 1));
            step(1);
        end
        m_valid = 1'b0; a_valid = 1'b0;
        pause = 1'b0;
        wait_issue("t2_iss0", 6'd1, 3'd2, t_now);
        wait_issue("t2_iss1", 6'd0, 3'd3, t_now);
        wait_issue("t2_iss2", 6'd1, 3'd2, t_now);
        wait_issue("t2_iss3", 6'd0, 3'd3, t_now);
        step(2);
        chk("t2_cnt", 32'(move_cnt), 32'd5);
        chk("t2_busy", 32'(busy), 32'd0);

        // Fill 8 deep with pause, 9th stalls; then 8 issues spaced 4 with gap=3
        pause = 1'b1; gap = 4'd3;
        for (int i = 0; i < 8; i++)
            push_m(6'(i % 6), 3'((i % 3) + 1), 1'b1, $sformatf("t3_push%0d", i));
        m_face = 6'd2; m_rot = 3'd2;
        #1 chk("t3_full_stall", 32'(m_ready), 32'd0);
        m_valid = 1'b0;
        chk("t3_busy", 32'(busy), 32'd1);
        pause = 1'b0;
        t_prev = -1;
        for (int i = 0; i < 8; i++) begin
            wait_issue($sformatf("t3_iss%0d", i), 6'(i % 6), 3'((i % 3) + 1), t_now);
            if (t_prev >= 0 && t_now >= 0)
                chk($sformatf("t3_space%0d", i), 32'(t_now - t_prev), 32'd4);
            t_prev = t_now;
        end
        step(6);
        chk("t3_cnt", 32'(move_cnt), 32'd13);

        // Illegal moves: consumed, flag err, never issued
        gap = 4'd0;
        a_valid = 1'b1; a_face = 6'd6; a_rot = 3'd1;
        #1 chk("t4_a_ready", 32'(a_ready), 32'd1);
        step(1);
        a_valid = 1'b0;
        chk("t4_err_a", 32'(err), 32'd1);
        m_valid = 1'b1; m_face = 6'd2; m_rot = 3'd0;
        #1 chk("t4_m_ready", 32'(m_ready), 32'd1);
        step(1);
        m_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t4_noissue%0d", i), 32'(nextRotation), 32'd0);
            step(1);
        end
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_cnt", 32'(move_cnt), 32'd13);
        chk("t4_err_sticky", 32'(err), 32'd1);

        // Flush with 5 queued
        pause = 1'b1;
        for (int i = 0; i < 5; i++)
            push_m(6'd3, 3'd1, 1'b1, $sformatf("t5_push%0d", i));
        chk("t5_busy_q", 32'(busy), 32'd1);
        flush = 1'b1;
        #1 chk("t5_flush_m_ready", 32'(m_ready), 32'd0);
        step(1);
        flush = 1'b0; m_valid = 1'b0;
        chk("t5_busy_after", 32'(busy), 32'd0);
        pause = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            chk($sformatf("t5_noissue%0d", i), 32'(nextRotation), 32'd0);
        end
        chk("t5_cnt", 32'(move_cnt), 32'd13);

        // Reset during GAP with 3 still queued
        gap = 4'd3; pause = 1'b1;
        f_exp = '{6'd4, 6'd5, 6'd1, 6'd2};
        r_exp = '{3'd1, 3'd2, 3'd3, 3'd1};
        for (int i = 0; i < 4; i++)
            push_m(f_exp[i], r_exp[i], 1'b1, $sformatf("t6_push%0d", i));
        m_valid = 1'b0;
        pause = 1'b0;
        step(1);
        chk("t6_issue_rot", 32'(nextRotation), 32'(r_exp[0]));
        step(1);
        chk("t6_gap_rot", 32'(nextRotation), 32'd0);
        chk("t6_gap_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        m_valid = 1'b1; m_face = 6'd0; m_rot = 3'd1;
        #1;
        chk("t6_rst_rot", 32'(nextRotation), 32'd0);
        chk("t6_rst_face", 32'(nextFaceMove), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_cnt", 32'(move_cnt), 32'd0);
        chk("t6_rst_err", 32'(err), 32'd0);
        chk("t6_rst_m_ready", 32'(m_ready), 32'd0);
        step(1);
        m_valid = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            chk($sformatf("t6_noissue%0d", i), 32'(nextRotation), 32'd0);
        end
        chk("t6_post_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/move_scheduler.md
MOVE_SCHEDULER -- requirements
Module: move_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, default 8: move FIFO entries, a power of two between 2 and 16.
REQ-002 SHALL have parameter CNT_W, default 16: width of the applied-move counter.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port m_valid, input, 1: manual requester has a move.
REQ-006 SHALL have port m_face, input, 6: manual requester face code.
REQ-007 SHALL have port m_rot, input, 3: manual requester quarter-turn count.
REQ-008 SHALL have port m_ready, output, 1: manual move accepted this cycle.
REQ-009 SHALL have ports a_valid, a_face, a_rot and a_ready: the auto requester (scrambler/solver), with the same widths and meaning as the manual ports.
REQ-010 SHALL have port gap, input, 4: idle cycles inserted after each issued move.
REQ-011 SHALL have port pause, input, 1: holds issue without dropping queued moves.
REQ-012 SHALL have port flush, input, 1: discards all queued moves.
REQ-013 SHALL have port nextFaceMove, output, 6: face code to the cube state block.
REQ-014 SHALL have port nextRotation, output, 3: turn count to the cube state block; 0 means no move.
REQ-015 SHALL have port busy, output, 1: FIFO non-empty or FSM not in IDLE.
REQ-016 SHALL have port err, output, 1: sticky flag, set by an illegal move.
REQ-017 SHALL have port move_cnt, output, CNT_W: moves issued since reset, saturating.

Function
REQ-018 SHALL treat a move as legal only if face is 0..5 and rot is 1..3.
REQ-019 SHALL accept a requester (ready=1) only when its valid=1, the FIFO is not full and it wins arbitration.
REQ-020 SHALL arbitrate round-robin between the two requesters: on contention, grant the one not granted at the last contention; the first contention after reset goes to manual.
REQ-021 SHALL accept at most one move per cycle.
REQ-022 SHALL, on accepting an illegal move, consume it (ready=1), not enqueue it, and set err.
REQ-023 SHALL assert ready combinationally from valid, FIFO full and arbiter state.
REQ-024 SHALL write an accepted legal move into the FIFO at the cycle edge.
REQ-025 SHALL run an FSM with states IDLE, ISSUE and GAP.
REQ-026 SHALL go from IDLE to ISSUE when the FIFO is non-empty and pause=0.
REQ-027 SHALL, in ISSUE, pop the FIFO head and drive it on nextFaceMove/nextRotation for exactly one cycle, then go to GAP if gap>0, else IDLE.
REQ-028 SHALL, in GAP, count gap cycles (value sampled on entry), then go to IDLE; pause has no effect during GAP.
REQ-029 SHALL drive nextFaceMove=0 and nextRotation=0 in every cycle other than ISSUE.
REQ-030 SHALL have minimum latency from acceptance to issue of 2 cycles: enqueue edge, IDLE→ISSUE edge.
REQ-031 SHALL allow push and pop in the same cycle when the FIFO is full or empty-plus-push; occupancy is unchanged and there is no loss.
REQ-032 SHALL wrap pointers modulo DEPTH and use one extra bit for full/empty.
REQ-033 SHALL, on flush, empty the FIFO, force the FSM to IDLE and deassert both readys that cycle; a move in ISSUE in that cycle is still output.
REQ-034 SHALL increment move_cnt once per ISSUE cycle and saturate it at all-ones.
REQ-035 SHALL clear err only by reset.

Reset
REQ-036 SHALL, on rst=1 asynchronously: empty the FIFO, set the FSM to IDLE, clear the gap counter, set the arbiter priority to manual, set err=0 and move_cnt=0.
REQ-037 SHALL output nextFaceMove=0 and nextRotation=0 during reset.
REQ-038 SHALL, on reset mid-ISSUE or mid-GAP, abandon the move with no partial output afterward.
REQ-039 SHALL hold m_ready and a_ready at 0 while rst=1.

Structure
REQ-040 SHALL put face codes (U=0, L=1, F=2, R=3, B=4, D=5), the legal rot range and the FSM state enum in shared package cube_pkg.
REQ-041 SHALL implement the FIFO as sub-module move_fifo, parameterised by DEPTH and width 9.
REQ-042 SHALL keep arbitration, the FSM and the counter in move_scheduler.

Verification
REQ-043 Bench SHALL cover: manual U/1 accepted, gap=0 → nextFaceMove=0, nextRotation=1 for one cycle, 2 cycles after acceptance; move_cnt=1.
REQ-044 Bench SHALL cover: both valid for 4 cycles (manual L/2, auto U/3) → grants alternate M,A,M,A; issue order matches.
REQ-045 Bench SHALL cover: 9 pushes into a DEPTH=8 FIFO with pause=1 → 9th stalls (ready=0); release pause → 8 issues with gap=3, spaced 4 cycles.
REQ-046 Bench SHALL cover: a_face=6 or m_rot=0 → ready=1, err=1, no issue, move_cnt unchanged.
REQ-047 Bench SHALL cover: flush with 5 queued → busy=0 next cycle, no further issue.
REQ-048 Bench SHALL cover: rst pulse during GAP with 3 queued → outputs 0, busy=0, move_cnt=0, err=0.
